// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory stage and the decode stage:
//   - mem_state_t  : memory-stage FSM state encoding
//   - F3_*         : funct3 load/store width codes
//   - norm_funct3  : maps unsupported funct3 codes onto the word access
//   - is_misaligned: alignment rule for a (normalised) access width
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned widths only exist for loads; anything unknown becomes a word access.
   function automatic logic [2:0] norm_funct3(input logic [2:0] f3, input logic is_load);
      logic [2:0] r;
      case (f3)
         F3_B, F3_H, F3_W: r = f3;
         F3_BU, F3_HU:     r = is_load ? f3 : F3_W;
         default:          r = F3_W;
      endcase
      return r;
   endfunction

   // Halfwords need bit 0 clear, words need both low bits clear.
   function automatic logic is_misaligned(input logic [2:0] f3n, input logic [1:0] lo);
      logic r;
      case (f3n)
         F3_H, F3_HU: r = lo[0];
         F3_W:        r = (lo != 2'b00);
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational lane handling for the memory stage.
//   Store side: st_funct3 (normalised), st_addr_lo, st_data
//               -> st_wdata (lane-replicated data), st_wmask (byte enables)
//   Load side : ld_funct3 (normalised), ld_addr_lo, ld_word
//               -> ld_data (selected byte/half, sign- or zero-extended)
// -----------------------------------------------------------------------------
module mem_align
   import mem_stage_pkg::*;
#(
   parameter int BIT_W = 32
) (
   input  logic [2:0]       st_funct3,
   input  logic [1:0]       st_addr_lo,
   input  logic [BIT_W-1:0] st_data,
   output logic [BIT_W-1:0] st_wdata,
   output logic [3:0]       st_wmask,
   input  logic [2:0]       ld_funct3,
   input  logic [1:0]       ld_addr_lo,
   input  logic [BIT_W-1:0] ld_word,
   output logic [BIT_W-1:0] ld_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Store lanes: replicate the operand across the word so any lane can take it.
   always_comb begin
      st_wdata = st_data;
      st_wmask = 4'b1111;
      case (st_funct3)
         F3_B: begin
            st_wdata = {(BIT_W/8){st_data[7:0]}};
            st_wmask = 4'b0001 << st_addr_lo;
         end
         F3_H: begin
            st_wdata = {(BIT_W/16){st_data[15:0]}};
            st_wmask = st_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = st_data;
            st_wmask = 4'b1111;
         end
      endcase
   end

   // Load extract: pick the addressed lane, then extend to full width.
   always_comb begin
      case (ld_addr_lo)
         2'd0:    byte_s = ld_word[7:0];
         2'd1:    byte_s = ld_word[15:8];
         2'd2:    byte_s = ld_word[23:16];
         default: byte_s = ld_word[31:24];
      endcase
      if (ld_addr_lo[1]) begin
         half_s = ld_word[31:16];
      end else begin
         half_s = ld_word[15:0];
      end
      case (ld_funct3)
         F3_B:    ld_data = {{(BIT_W-8){byte_s[7]}}, byte_s};
         F3_BU:   ld_data = {{(BIT_W-8){1'b0}}, byte_s};
         F3_H:    ld_data = {{(BIT_W-16){half_s[15]}}, half_s};
         F3_HU:   ld_data = {{(BIT_W-16){1'b0}}, half_s};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Pipeline memory stage: passes ALU results straight to write-back, runs
// loads/stores against a stalling data cache, and drops misaligned accesses.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_*                     result from EX (valid/ready handshake)
//   dcache_*                 word-addressed cache request / response
//   wb_*                     registered write-back result (one-cycle valid)
//   misalign                 one-cycle pulse when an access was dropped
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int BIT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [BIT_W-1:0] ex_alu_out,
   input  logic [BIT_W-1:0] ex_rs2_data,
   input  logic             ex_mem_read,
   input  logic             ex_mem_write,
   input  logic [2:0]       ex_funct3,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_write,
   output logic             dcache_ren,
   output logic             dcache_wen,
   output logic [BIT_W-3:0] dcache_addr,
   output logic [BIT_W-1:0] dcache_wdata,
   output logic [3:0]       dcache_wmask,
   input  logic [BIT_W-1:0] dcache_rdata,
   input  logic             dcache_stall,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic [BIT_W-1:0] wb_data,
   output logic             wb_reg_write,
   output logic             misalign
);

   mem_state_t       state_q, state_d;
   logic [BIT_W-1:0] addr_q, addr_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [4:0]       rd_q, rd_d;
   logic             reg_write_q, reg_write_d;
   logic             is_load_q, is_load_d;
   logic             ren_q, ren_d;
   logic             wen_q, wen_d;
   logic [3:0]       wmask_q, wmask_d;
   logic [BIT_W-1:0] wdata_q, wdata_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [BIT_W-1:0] wb_data_q, wb_data_d;
   logic             wb_reg_write_q, wb_reg_write_d;
   logic             misalign_q, misalign_d;

   logic             is_mem_s;
   logic             is_load_s;
   logic [2:0]       f3n_s;
   logic             mis_s;
   logic [BIT_W-1:0] st_wdata_s;
   logic [3:0]       st_wmask_s;
   logic [BIT_W-1:0] ld_data_s;

   // A request with both mem flags set behaves as a load.
   assign is_mem_s  = ex_mem_read | ex_mem_write;
   assign is_load_s = ex_mem_read;
   assign f3n_s     = norm_funct3(ex_funct3, is_load_s);
   assign mis_s     = is_misaligned(f3n_s, ex_alu_out[1:0]);

   mem_align #(.BIT_W(BIT_W)) u_align (
      .st_funct3  (f3n_s),
      .st_addr_lo (ex_alu_out[1:0]),
      .st_data    (ex_rs2_data),
      .st_wdata   (st_wdata_s),
      .st_wmask   (st_wmask_s),
      .ld_funct3  (funct3_q),
      .ld_addr_lo (addr_q[1:0]),
      .ld_word    (dcache_rdata),
      .ld_data    (ld_data_s)
   );

   // Next-state and next-output logic for the IDLE/ACCESS/DONE sequence.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      funct3_d       = funct3_q;
      rd_d           = rd_q;
      reg_write_d    = reg_write_q;
      is_load_d      = is_load_q;
      ren_d          = ren_q;
      wen_d          = wen_q;
      wmask_d        = wmask_q;
      wdata_d        = wdata_q;
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      misalign_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ex_valid && !is_mem_s) begin
               wb_valid_d     = 1'b1;
               wb_rd_d        = ex_rd;
               wb_data_d      = ex_alu_out;
               wb_reg_write_d = ex_reg_write;
            end else if (ex_valid && mis_s) begin
               // Dropped access still retires so the pipeline sees a slot.
               wb_valid_d = 1'b1;
               wb_rd_d    = ex_rd;
               wb_data_d  = ex_alu_out;
               misalign_d = 1'b1;
            end else if (ex_valid) begin
               state_d     = ST_ACCESS;
               addr_d      = ex_alu_out;
               funct3_d    = f3n_s;
               rd_d        = ex_rd;
               reg_write_d = ex_reg_write;
               is_load_d   = is_load_s;
               ren_d       = is_load_s;
               wen_d       = ~is_load_s;
               wmask_d     = is_load_s ? 4'b0000 : st_wmask_s;
               wdata_d     = st_wdata_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (!dcache_stall) begin
               state_d        = ST_DONE;
               ren_d          = 1'b0;
               wen_d          = 1'b0;
               wmask_d        = 4'b0000;
               wb_valid_d     = 1'b1;
               wb_rd_d        = rd_q;
               wb_reg_write_d = is_load_q & reg_write_q;
               wb_data_d      = is_load_q ? ld_data_s : addr_q;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            wmask_d = 4'b0000;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         addr_q         <= {BIT_W{1'b0}};
         funct3_q       <= 3'b000;
         rd_q           <= 5'd0;
         reg_write_q    <= 1'b0;
         is_load_q      <= 1'b0;
         ren_q          <= 1'b0;
         wen_q          <= 1'b0;
         wmask_q        <= 4'b0000;
         wdata_q        <= {BIT_W{1'b0}};
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_data_q      <= {BIT_W{1'b0}};
         wb_reg_write_q <= 1'b0;
         misalign_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         funct3_q       <= funct3_d;
         rd_q           <= rd_d;
         reg_write_q    <= reg_write_d;
         is_load_q      <= is_load_d;
         ren_q          <= ren_d;
         wen_q          <= wen_d;
         wmask_q        <= wmask_d;
         wdata_q        <= wdata_d;
         wb_valid_q     <= wb_valid_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         wb_reg_write_q <= wb_reg_write_d;
         misalign_q     <= misalign_d;
      end
   end

   assign ex_ready     = (state_q == ST_IDLE);
   assign dcache_ren   = ren_q;
   assign dcache_wen   = wen_q;
   assign dcache_addr  = addr_q[BIT_W-1:2];
   assign dcache_wdata = wdata_q;
   assign dcache_wmask = wmask_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign wb_reg_write = wb_reg_write_q;
   assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int BIT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             ex_valid;
   logic             ex_ready;
   logic [BIT_W-1:0] ex_alu_out;
   logic [BIT_W-1:0] ex_rs2_data;
   logic             ex_mem_read;
   logic             ex_mem_write;
   logic [2:0]       ex_funct3;
   logic [4:0]       ex_rd;
   logic             ex_reg_write;
   logic             dcache_ren;
   logic             dcache_wen;
   logic [BIT_W-3:0] dcache_addr;
   logic [BIT_W-1:0] dcache_wdata;
   logic [3:0]       dcache_wmask;
   logic [BIT_W-1:0] dcache_rdata;
   logic             dcache_stall;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [BIT_W-1:0] wb_data;
   logic             wb_reg_write;
   logic             misalign;

   always #5 clk = ~clk;

   mem_stage #(.BIT_W(BIT_W)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
      .ex_rs2_data(ex_rs2_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .dcache_ren(dcache_ren), .dcache_wen(dcache_wen), .dcache_addr(dcache_addr),
      .dcache_wdata(dcache_wdata), .dcache_wmask(dcache_wmask), .dcache_rdata(dcache_rdata),
      .dcache_stall(dcache_stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
      .misalign(misalign)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int cmp_c = 0;
   bit chk_en = 1'b0;
   bit last_mem = 1'b0;
   int ren_run = 0;
   int last_ren_run = 0;
   logic [31:0] last_w_addr = 32'd0;
   logic [31:0] last_w_mask = 32'd0;
   logic [31:0] last_w_data = 32'd0;

   // Expected behaviour per cycle number (observed just after that clock edge)
   bit          exp_busy[int];
   bit          exp_ren[int];
   bit          exp_wen[int];
   logic [31:0] exp_addr[int];
   logic [31:0] exp_mask[int];
   logic [31:0] exp_wdata[int];
   bit          exp_v[int];
   logic [31:0] exp_rd[int];
   bit          exp_rw[int];
   bit          exp_mis[int];
   bit          exp_dchk[int];
   logic [31:0] exp_data[int];

   typedef struct {
      bit          is_mem;
      bit          is_load;
      bit          mis;
      int          size;
      bit          sgn;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } dec_t;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference decode: access size in bytes, alignment by modulo, lanes by shifting.
   function automatic dec_t decode(input bit mr, input bit mw, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] rs2);
      dec_t d;
      int code;
      int off;
      logic [63:0] lane;
      code = int'(f3);
      d.is_mem  = mr | mw;
      d.is_load = mr;
      if (d.is_load) begin
         if (!(code inside {0, 1, 2, 4, 5})) code = 2;
      end else begin
         if (code > 2) code = 2;
      end
      d.size = (code % 4 == 0) ? 1 : ((code % 4 == 1) ? 2 : 4);
      d.sgn  = (code < 4);
      off    = int'(addr % 32'd4);
      d.mis  = d.is_mem && ((off % d.size) != 0);
      d.mask = 4'(((1 << d.size) - 1) << off);
      lane   = 64'(rs2) & ((64'd1 << (8 * d.size)) - 64'd1);
      d.wdata = 32'd0;
      for (int i = 0; i < 4 / d.size; i++) d.wdata = d.wdata | 32'(lane << (8 * d.size * i));
      return d;
   endfunction

   function automatic logic [31:0] load_val(input dec_t d, input logic [31:0] addr, input logic [31:0] word);
      logic [63:0] v;
      int off;
      int nb;
      off = int'(addr % 32'd4);
      nb  = 8 * d.size;
      v   = (64'(word) >> (8 * off)) & ((64'd1 << nb) - 64'd1);
      if (d.sgn && d.size < 4 && v[nb-1]) v = v - (64'd1 << nb);
      return v[31:0];
   endfunction

   task automatic junk();
      ex_valid     = 1'($urandom_range(0, 1));
      ex_alu_out   = $urandom();
      ex_rs2_data  = $urandom();
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_mem_write = 1'($urandom_range(0, 1));
      ex_funct3    = 3'($urandom_range(0, 7));
      ex_rd        = 5'($urandom_range(0, 31));
      ex_reg_write = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         ex_valid = 1'b0;
         @(negedge clk);
      end
      last_mem = 1'b0;
   endtask

   // Present one EX result at a negedge while the stage is idle, record what the
   // stage must do on every following cycle, and act as the cache. Returns at the
   // negedge where wb_valid is expected.
   task automatic do_txn(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [4:0] rd, input bit rw,
                         input int nstall, input logic [31:0] word);
      dec_t d;
      int c;
      if (last_mem) begin
         ex_valid = 1'b0;
         @(negedge clk);
      end
      last_mem = 1'b0;
      d = decode(mr, mw, f3, a, rs2);
      c = cyc;
      ex_valid = 1'b1; ex_alu_out = a; ex_rs2_data = rs2; ex_mem_read = mr; ex_mem_write = mw;
      ex_funct3 = f3; ex_rd = rd; ex_reg_write = rw;
      if (!d.is_mem || d.mis) begin
         exp_v[c+1]    = 1'b1;
         exp_rd[c+1]   = 32'(rd);
         exp_rw[c+1]   = d.is_mem ? 1'b0 : rw;
         exp_mis[c+1]  = d.mis;
         exp_dchk[c+1] = !d.is_mem;
         exp_data[c+1] = a;
         @(negedge clk);
         ex_valid = 1'b0;
      end else begin
         for (int k = 0; k <= nstall; k++) begin
            exp_busy[c+1+k]  = 1'b1;
            exp_ren[c+1+k]   = d.is_load;
            exp_wen[c+1+k]   = !d.is_load;
            exp_addr[c+1+k]  = a >> 2;
            exp_mask[c+1+k]  = 32'(d.mask);
            exp_wdata[c+1+k] = d.wdata;
         end
         exp_busy[c+2+nstall] = 1'b1;
         exp_v[c+2+nstall]    = 1'b1;
         exp_rd[c+2+nstall]   = 32'(rd);
         exp_rw[c+2+nstall]   = d.is_load && rw;
         exp_mis[c+2+nstall]  = 1'b0;
         exp_dchk[c+2+nstall] = d.is_load;
         exp_data[c+2+nstall] = load_val(d, a, word);
         for (int k = 0; k <= nstall; k++) begin
            @(negedge clk);
            junk();
            dcache_stall = (k < nstall);
            dcache_rdata = (k < nstall) ? $urandom() : word;
         end
         @(negedge clk);
         junk();
         dcache_stall = 1'($urandom_range(0, 1));
         dcache_rdata = $urandom();
         last_mem = 1'b1;
      end
   endtask

   task automatic reset_mid_access();
      if (last_mem) begin
         ex_valid = 1'b0;
         @(negedge clk);
      end
      last_mem = 1'b0;
      chk_en = 1'b0;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
      ex_alu_out = 32'h0000_0100; ex_rd = 5'd3; ex_reg_write = 1'b1; dcache_stall = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0;
      chk("rst_pre_ren", 32'(dcache_ren), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_mid_ren", 32'(dcache_ren), 32'd0);
      chk("rst_mid_wen", 32'(dcache_wen), 32'd0);
      chk("rst_mid_wmask", 32'(dcache_wmask), 32'd0);
      chk("rst_mid_ready", 32'(ex_ready), 32'd1);
      chk("rst_mid_wb_data", wb_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dcache_stall = 1'b0;
      dcache_rdata = $urandom();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_post_wb_valid", 32'(wb_valid), 32'd0);
         chk("rst_post_ren", 32'(dcache_ren), 32'd0);
         chk("rst_post_ready", 32'(ex_ready), 32'd1);
      end
      exp_busy.delete(); exp_ren.delete(); exp_wen.delete(); exp_addr.delete();
      exp_mask.delete(); exp_wdata.delete(); exp_v.delete(); exp_rd.delete();
      exp_rw.delete(); exp_mis.delete(); exp_dchk.delete(); exp_data.delete();
      ren_run = 0;
      chk_en = 1'b1;
   endtask

   // Per-cycle compare of every output against the recorded expectations.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (chk_en) begin
            cmp_c = cyc;
            chk("ex_ready", 32'(ex_ready), exp_busy.exists(cmp_c) ? 32'd0 : 32'd1);
            chk("dcache_ren", 32'(dcache_ren), (exp_ren.exists(cmp_c) && exp_ren[cmp_c]) ? 32'd1 : 32'd0);
            chk("dcache_wen", 32'(dcache_wen), (exp_wen.exists(cmp_c) && exp_wen[cmp_c]) ? 32'd1 : 32'd0);
            if (exp_addr.exists(cmp_c)) chk("dcache_addr", 32'(dcache_addr), exp_addr[cmp_c]);
            if (exp_wen.exists(cmp_c) && exp_wen[cmp_c]) begin
               chk("dcache_wmask", 32'(dcache_wmask), exp_mask[cmp_c]);
               chk("dcache_wdata", dcache_wdata, exp_wdata[cmp_c]);
            end
            if (exp_v.exists(cmp_c)) begin
               chk("wb_valid", 32'(wb_valid), 32'd1);
               chk("wb_rd", 32'(wb_rd), exp_rd[cmp_c]);
               chk("wb_reg_write", 32'(wb_reg_write), exp_rw[cmp_c] ? 32'd1 : 32'd0);
               chk("misalign", 32'(misalign), exp_mis[cmp_c] ? 32'd1 : 32'd0);
               if (exp_dchk[cmp_c]) chk("wb_data", wb_data, exp_data[cmp_c]);
            end else begin
               chk("wb_valid_idle", 32'(wb_valid), 32'd0);
               chk("wb_reg_write_idle", 32'(wb_reg_write), 32'd0);
               chk("misalign_idle", 32'(misalign), 32'd0);
            end
            if (dcache_ren) begin
               ren_run = ren_run + 1;
            end else begin
               if (ren_run != 0) last_ren_run = ren_run;
               ren_run = 0;
            end
            if (dcache_wen) begin
               last_w_addr = 32'(dcache_addr);
               last_w_mask = 32'(dcache_wmask);
               last_w_data = dcache_wdata;
            end
         end
      end
   end

   initial begin
      dec_t d;
      int op;
      logic [31:0] a;
      rst = 1'b1;
      ex_valid = 1'b0; ex_alu_out = 32'd0; ex_rs2_data = 32'd0; ex_mem_read = 1'b0;
      ex_mem_write = 1'b0; ex_funct3 = 3'b000; ex_rd = 5'd0; ex_reg_write = 1'b0;
      dcache_rdata = 32'd0; dcache_stall = 1'b0;
      #7;
      chk("reset_wb_valid", 32'(wb_valid), 32'd0);
      chk("reset_wb_reg_write", 32'(wb_reg_write), 32'd0);
      chk("reset_wb_rd", 32'(wb_rd), 32'd0);
      chk("reset_wb_data", wb_data, 32'd0);
      chk("reset_misalign", 32'(misalign), 32'd0);
      chk("reset_ren", 32'(dcache_ren), 32'd0);
      chk("reset_wen", 32'(dcache_wen), 32'd0);
      chk("reset_wmask", 32'(dcache_wmask), 32'd0);
      chk("reset_ready", 32'(ex_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      idle(1);

      // Hand-computed values that pin the reference model.
      d = decode(1'b1, 1'b0, 3'b000, 32'h103, 32'd0);
      chk("model_lb", load_val(d, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
      d = decode(1'b1, 1'b0, 3'b101, 32'h2, 32'd0);
      chk("model_lhu", load_val(d, 32'h2, 32'h8765_4321), 32'h0000_8765);
      d = decode(1'b1, 1'b0, 3'b001, 32'h2, 32'd0);
      chk("model_lh", load_val(d, 32'h2, 32'h8765_4321), 32'hFFFF_8765);
      d = decode(0, 1, 3'b001, 32'h202, 32'hABCD_1234);
      chk("model_sh_mask", 32'(d.mask), 32'h0000_000C);
      chk("model_sh_wdata", d.wdata, 32'h1234_1234);
      d = decode(1'b1, 1'b0, 3'b111, 32'h2, 32'd0);
      chk("model_bad_f3_mis", 32'(d.mis), 32'd1);
      d = decode(1'b0, 1'b1, 3'b100, 32'h1, 32'd0);
      chk("model_st_bu_is_sw", 32'(d.mis), 32'd1);

      // Directed scenarios
      do_txn(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 0, 32'd0);
      chk("add_valid", 32'(wb_valid), 32'd1);
      chk("add_data", wb_data, 32'h0000_1234);
      chk("add_rd", 32'(wb_rd), 32'd5);

      do_txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 1'b1, 0, 32'h80FF_0000);
      chk("lb_valid", 32'(wb_valid), 32'd1);
      chk("lb_data", wb_data, 32'hFFFF_FF80);

      do_txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd9, 1'b1, 1, 32'd0);
      chk("sh_addr", last_w_addr, 32'h0000_0080);
      chk("sh_mask", last_w_mask, 32'h0000_000C);
      chk("sh_wdata", last_w_data, 32'h1234_1234);
      chk("sh_reg_write", 32'(wb_reg_write), 32'd0);
      chk("sh_rd", 32'(wb_rd), 32'd9);

      do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd11, 1'b1, 3, 32'hCAFE_F00D);
      chk("lw_stall_ren_cycles", 32'(last_ren_run), 32'd4);
      chk("lw_stall_data", wb_data, 32'hCAFE_F00D);

      do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 5'd12, 1'b1, 0, 32'd0);
      chk("lw_mis_pulse", 32'(misalign), 32'd1);
      chk("lw_mis_reg_write", 32'(wb_reg_write), 32'd0);
      chk("lw_mis_ren", 32'(dcache_ren), 32'd0);

      do_txn(1'b1, 1'b1, 3'b000, 32'h0000_0101, 32'hFFFF_FFFF, 5'd13, 1'b1, 0, 32'h0000_7F00);
      chk("rw_both_load_data", wb_data, 32'h0000_007F);
      chk("rw_both_reg_write", 32'(wb_reg_write), 32'd1);

      reset_mid_access();

      // Randomised traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 3));
         a = $urandom();
         if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
         do_txn((op == 1) || (op == 3), (op == 2) || (op == 3), 3'($urandom_range(0, 7)), a,
                $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), $urandom());
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
